// File: rtl/rr_arbiter_4req_pkg.sv
// Shared constants, FSM state type and grant helpers for the 4-requester round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_4req_if.sv
// Request/grant bundle between the requester blocks (master) and the arbiter (slave).
interface rr_arbiter_4req_if
  import arb_pkg::*;
();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             tmo;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid, input tmo);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output tmo);

endinterface

// File: rtl/rr_arbiter_4req_prio_encoder.sv
// Combinational rotating priority encoder: first set req bit at or above (ptr+1) mod 4, wrapping.
module rr_prio_encoder
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] offset;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] pidx;

  assign offset = ptr + 1'b1;

  // Rotate so the highest-priority requester lands at bit 0, encode, then undo the rotation.
  always_comb begin
    rot  = '0;
    pidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(i) + offset];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pidx = IDX_W'(i);
    end
  end

  assign idx   = pidx + offset;
  assign valid = |req;

endmodule

// File: rtl/rr_arbiter_4req.sv
// Round-robin arbiter for 4 requesters with registered one-hot/index/valid grant; 1-cycle grant latency.
// Define ARB_TIMEOUT_EN to force release (tmo pulse) after MAX_HOLD consecutive grant cycles.
module rr_arbiter_4req
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter_4req_if.slave   bus
);

  localparam bit HOLD_CFG_OK = (MAX_HOLD >= 2) && (MAX_HOLD <= 15) && ((1 << CNT_W) > MAX_HOLD);

  if (!HOLD_CFG_OK) begin : g_bad_hold_cfg
    $error("rr_arbiter_4req: MAX_HOLD must be 2..15 and fit in CNT_W bits");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  rr_prio_encoder u_enc (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // ptr_q doubles as the owner index while in GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE, RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
        if (enc_valid) begin
          state_d = GRANT;
          ptr_d   = enc_idx;
          gnt_d   = onehot_from_idx(enc_idx);
          idx_d   = enc_idx;
          vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[ptr_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d = RELEASE;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.tmo = tmo_q;
`else
  assign bus.tmo = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Directed bench for rr_arbiter_4req: reset, latency, rotation, wrap, non-preemption and hold limit.
module tb_rr_arbiter_4req;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  rr_arbiter_4req_if arb_bus ();

  rr_arbiter_4req dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                     input logic ev, input logic et);
    n_vec++;
    assert (arb_bus.gnt === eg) else begin
      n_err++;
      $error("FAIL %s gnt: got %b want %b", tag, arb_bus.gnt, eg);
    end
    n_vec++;
    assert (arb_bus.gnt_idx === ei) else begin
      n_err++;
      $error("FAIL %s gnt_idx: got %0d want %0d", tag, arb_bus.gnt_idx, ei);
    end
    n_vec++;
    assert (arb_bus.gnt_valid === ev) else begin
      n_err++;
      $error("FAIL %s gnt_valid: got %b want %b", tag, arb_bus.gnt_valid, ev);
    end
    n_vec++;
    assert (arb_bus.tmo === et) else begin
      n_err++;
      $error("FAIL %s tmo: got %b want %b", tag, arb_bus.tmo, et);
    end
  endtask

  logic [3:0] rr_gnt [5];
  logic [1:0] rr_idx [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    arb_bus.req = 4'b0000;
    tick();
    chk("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset mid-grant
    arb_bus.req = 4'b0100;
    tick();
    chk("t1_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk("t1_hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    chk("t1_async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("t1_in_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    arb_bus.req = 4'b0001;
    tick();
    chk("t1_after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    arb_bus.req = 4'b0000;
    tick();
    chk("t1_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 3, ptr now 0
    arb_bus.req = 4'b1000;
    tick();
    chk("t2_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t2_hold3", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    arb_bus.req = 4'b0000;
    tick();
    chk("t2_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("t2_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    arb_bus.req = 4'b0010;
    tick();
    chk("t2_idle_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    arb_bus.req = 4'b0000;
    tick();
    tick();

    // Round-robin from a fresh reset (ptr=3)
    rst = 1'b1;
    #2;
    rst = 1'b0;
    arb_bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_rr_first", rr_gnt[k], rr_idx[k], 1'b1, 1'b0);
      tick();
      chk("t3_rr_second", rr_gnt[k], rr_idx[k], 1'b1, 1'b0);
      arb_bus.req = 4'b1111 & ~rr_gnt[k];
      tick();
      chk("t3_rr_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
      arb_bus.req = 4'b1111;
      tick();
    end
    chk("t3_rr_next", 4'b0010, 2'd1, 1'b1, 1'b0);
    arb_bus.req = 4'b0000;
    tick();
    tick();

    // Wrap and skip: owner 2, then req=0101 during RELEASE
    arb_bus.req = 4'b0100;
    tick();
    chk("t4_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    arb_bus.req = 4'b0000;
    tick();
    chk("t4_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    arb_bus.req = 4'b0101;
    tick();
    chk("t4_wrap_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
    arb_bus.req = 4'b0000;
    tick();
    tick();

    // Non-preemption of owner 3
    arb_bus.req = 4'b1000;
    tick();
    chk("t6_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      arb_bus.req = (j % 2 == 0) ? 4'b1001 : 4'b1111;
      tick();
      chk("t6_no_preempt", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    arb_bus.req = 4'b0111;
    tick();
    chk("t6_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("t6_next_is0", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    arb_bus.req = 4'b0000;
    tick();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    arb_bus.req = 4'b0011;
    tick();
    chk("t5_own0_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int j = 1; j < 8; j++) begin
      tick();
      chk("t5_own0_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk("t5_tmo0", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk("t5_own1_c0", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int j = 1; j < 8; j++) begin
      tick();
      chk("t5_own1_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk("t5_tmo1", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk("t5_back_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int j = 1; j < 8; j++) begin
      tick();
      chk("t5_own0_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    arb_bus.req = 4'b0010;
    tick();
    chk("t5_drop_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("t5_after_drop", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("no_timeout_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    arb_bus.req = 4'b0000;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4req.md
Name: rr_arbiter_4req

Overview:
- Round-robin arbiter sharing one downstream resource among 4 requesters.
- Grant is reported three ways: one-hot, as a 2-bit encoded index, and with a valid flag. The index/valid pair matches the 4-bit encoder's output convention.
- Sequences ownership with a small FSM: request → grant → hold → release.
- Sits between requester blocks and the shared datapath; downstream uses gnt_idx as a mux select.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per owner. Used only when ARB_TIMEOUT_EN is defined; legal range 2..15.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  request vector; req[i] is requester i, level-sensitive
- gnt  output  4  registered one-hot grant; all zero when no owner
- gnt_idx  output  2  registered binary index of the owner; 0 when gnt_valid=0
- gnt_valid  output  1  registered; 1 while any gnt bit is set
- tmo  output  1  registered one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset: asynchronous and active-high. Effects while rst=1:
  - gnt=0, gnt_idx=0, gnt_valid=0, tmo=0.
  - state=IDLE, ptr=3 (the first search starts at requester 0), hold count=0.
  - Takes effect immediately even mid-grant; no release cycle is generated.
- Search order: starting at (ptr+1) mod 4 and moving upward with wrap, the first set req bit wins.
- ptr update: ptr takes the winner index when a grant is issued.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req≠0, arbitrate; next cycle state=GRANT with gnt/gnt_idx/gnt_valid set.
  - Otherwise stay in IDLE.
- GRANT:
  - Hold the grant while req[owner]=1. Other requests are ignored; there is no preemption.
  - If req[owner]=0, next cycle state=RELEASE and all grant outputs go to 0.
- RELEASE:
  - Exactly one cycle with the grant outputs at 0 (bus turnaround).
  - Arbitrates on the current req. Any bit set → GRANT next cycle; none set → IDLE.
- Latencies:
  - Request to grant: 1 cycle from IDLE.
  - Owner drop to grant deassert: 1 cycle.
  - Owner drop to next grant: 2 cycles.
- Fairness:
  - The previous owner has lowest priority at the next arbitration.
  - With all 4 requesting continuously and each dropping after service, grants rotate 0,1,2,3,0…
- Simultaneous events:
  - Owner drops req in the same cycle another requester raises req: standard RELEASE then rotation.
  - Owner re-raises req during RELEASE: it competes at lowest priority.
- req glitches on non-owners during GRANT have no effect.
- gnt_idx always equals the encoding of gnt; gnt_valid = |gnt. Both are registered together, with no combinational path from req.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - The hold counter clears on grant issue and increments every GRANT cycle.
  - When count = MAX_HOLD-1 and req[owner] is still 1, the FSM is forced to RELEASE next cycle, with tmo=1 for that one cycle.
  - The owner must rearbitrate and has lowest priority.
  - If the owner drops req on the same cycle the limit is reached, this is a normal release with tmo=0.
- When undefined:
  - No counter logic is built; tmo is tied to 0.
  - Grants are held indefinitely.

Decomposition:
- Package arb_pkg:
  - N_REQ=4, IDX_W=2.
  - State enum arb_state_t {IDLE, GRANT, RELEASE}.
  - Function onehot_from_idx.
- Sub-module rr_prio_encoder, combinational:
  - Inputs req[3:0], ptr[1:0]; outputs idx[1:0], valid.
  - Rotate req right by ptr+1, apply a fixed lowest-index-first priority encode, then add the offset back mod 4.
  - Instantiated once in the top FSM.

Test Plan:
1. Reset mid-grant: req=4'b0100 held, grant seen (gnt=0100, gnt_idx=2), then pulse rst → all outputs 0 in the same cycle; after release of rst with req=4'b0001 → gnt=0001 one cycle later.
2. Single requester: req=4'b1000 at cycle 10 → cycle 11 gnt=1000, gnt_idx=3, gnt_valid=1; drop at cycle 15 → cycle 16 all grant outputs 0; cycle 17 IDLE.
3. Round-robin: req=4'b1111 after reset, each owner drops its bit for one cycle after 2 grant cycles → grant order 0,1,2,3,0 with exactly one zero-grant cycle between each.
4. Wrap and skip: ptr=2 (last owner 2), req=4'b0101 in RELEASE → next gnt_idx=0, not 2.
5. ARB_TIMEOUT_EN, MAX_HOLD=8: req=4'b0011 held constant → requester 0 granted 8 cycles, tmo pulse, 1 zero cycle, requester 1 granted 8 cycles, tmo, back to 0.
6. Non-preemption: owner 3 granted; req toggles 4'b1001→4'b1111 repeatedly → gnt stays 1000 until req[3]=0.
